// File: rtl/branch_unit_if.sv
// ---------------------------------------------------------------------------
// branch_unit_if
// Groups the request and result signals of branch_unit.
//   master : the requester (drives the request, receives the results)
//   slave  : branch_unit itself
// Request : start, flush, ir[31:0], bus_in[31:0], pc_in[31:0]
// Result  : busy, con_q, pc_out[31:0], pc_load, done,
//           branch_count[15:0], taken_count[15:0]
// ---------------------------------------------------------------------------
interface branch_unit_if;
    logic        start;
    logic        flush;
    logic [31:0] ir;
    logic [31:0] bus_in;
    logic [31:0] pc_in;
    logic        busy;
    logic        con_q;
    logic [31:0] pc_out;
    logic        pc_load;
    logic        done;
    logic [15:0] branch_count;
    logic [15:0] taken_count;

    modport master (
        output start, flush, ir, bus_in, pc_in,
        input  busy, con_q, pc_out, pc_load, done, branch_count, taken_count
    );

    modport slave (
        input  start, flush, ir, bus_in, pc_in,
        output busy, con_q, pc_out, pc_load, done, branch_count, taken_count
    );
endinterface

// File: rtl/branch_unit.sv
// ---------------------------------------------------------------------------
// branch_unit
// Multi-cycle conditional branch resolver.  A start pulse captures the
// instruction, tested register and PC; the unit then evaluates the condition
// (EVAL), computes PC + sign-extended displacement (CALC) and finally issues
// a one-cycle done strobe with pc_load = condition (COMMIT).
//
// Ports
//   clock    : single clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : branch_unit_if.slave
//              start/flush/ir/bus_in/pc_in in,
//              busy/con_q/pc_out/pc_load/done/branch_count/taken_count out
//
// Parameter
//   OFFSET_W : width of the displacement field ir[OFFSET_W-1:0] (< 32)
//
// Optional feature
//   BRANCH_UNIT_STATS_EN : when defined, saturating 16-bit counters of
//   committed and taken branches; otherwise both counters read 0 and no
//   counter flops exist.
// ---------------------------------------------------------------------------
module branch_unit #(
    parameter int OFFSET_W = 19
) (
    input  logic          clock,
    input  logic          reset_n,
    branch_unit_if.slave  bus
);

    localparam int EXT_W = 32 - OFFSET_W;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        CALC,
        COMMIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                latch_en;
    logic                eval_en;
    logic                calc_en;
    logic                commit_en;

    logic [1:0]          cond_code;
    logic [OFFSET_W-1:0] offset;
    logic [31:0]         operand;
    logic [31:0]         base_pc;

    logic                cond_flag;
    logic [31:0]         target_pc;
    logic                done_pulse;
    logic                load_pulse;
    logic                cond_hit;

    // Upper instruction bits are not part of the branch encoding.
    logic                unused_ir;
    assign unused_ir = ^bus.ir;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        latch_en  = 1'b0;
        eval_en   = 1'b0;
        calc_en   = 1'b0;
        commit_en = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    latch_en  = 1'b1;
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else begin
                    eval_en   = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else begin
                    calc_en   = 1'b1;
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                commit_en = !bus.flush;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------ condition test
    always_comb begin
        cond_hit = 1'b0;
        case (cond_code)
            2'b00: cond_hit = (operand == '0);
            2'b01: cond_hit = (operand != '0);
            2'b10: cond_hit = !operand[31] && (operand != '0);
            2'b11: cond_hit = operand[31];
            default: cond_hit = 1'b0;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cond_code <= '0;
            offset    <= '0;
            operand   <= '0;
            base_pc   <= '0;
        end else if (latch_en) begin
            cond_code <= bus.ir[20:19];
            offset    <= bus.ir[OFFSET_W-1:0];
            operand   <= bus.bus_in;
            base_pc   <= bus.pc_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cond_flag <= 1'b0;
            target_pc <= '0;
        end else begin
            if (eval_en) begin
                cond_flag <= cond_hit;
            end
            if (calc_en) begin
                target_pc <= base_pc + {{EXT_W{offset[OFFSET_W-1]}}, offset};
            end
        end
    end

    // The strobes are registered on the COMMIT edge so that they appear in
    // the fourth cycle after the start edge; busy has already dropped then.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_pulse <= 1'b0;
            load_pulse <= 1'b0;
        end else begin
            done_pulse <= commit_en;
            load_pulse <= commit_en && cond_flag;
        end
    end

    // ---------------------------------------------------------- statistics
`ifdef BRANCH_UNIT_STATS_EN
    logic [15:0] branch_cnt;
    logic [15:0] taken_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else if (commit_en) begin
            if (branch_cnt != '1) begin
                branch_cnt <= branch_cnt + 16'd1;
            end
            if (cond_flag && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + 16'd1;
            end
        end
    end

    assign bus.branch_count = branch_cnt;
    assign bus.taken_count  = taken_cnt;
`else
    assign bus.branch_count = '0;
    assign bus.taken_count  = '0;
`endif

    // ------------------------------------------------------------- outputs
    assign bus.busy    = (state != IDLE);
    assign bus.con_q   = cond_flag;
    assign bus.pc_out  = target_pc;
    assign bus.done    = done_pulse;
    assign bus.pc_load = load_pulse;

endmodule

// File: tb/tb_branch_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_unit
// Directed test of branch_unit: reset state, the four condition codes,
// positive/negative/wrapping displacements, start-while-busy, flush in CALC,
// flush+start in IDLE, asynchronous reset in EVAL and statistics counters
// (expected values depend on BRANCH_UNIT_STATS_EN).
// ---------------------------------------------------------------------------
module tb_branch_unit;

    logic clock;
    logic reset_n;

    int unsigned applied;
    int unsigned miscompares;

`ifdef BRANCH_UNIT_STATS_EN
    localparam logic [31:0] BR3   = 32'd3;
    localparam logic [31:0] TK3   = 32'd2;
    localparam logic [31:0] BR7   = 32'd7;
    localparam logic [31:0] TK7   = 32'd5;
`else
    localparam logic [31:0] BR3   = 32'd0;
    localparam logic [31:0] TK3   = 32'd0;
    localparam logic [31:0] BR7   = 32'd0;
    localparam logic [31:0] TK7   = 32'd0;
`endif

    branch_unit_if bus ();

    branch_unit #(.OFFSET_W(19)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp_v);
        applied++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_op(input logic [1:0] cond, input logic [31:0] operand,
                            input logic [31:0] pc, input logic [18:0] off);
        bus.ir     = {11'h000, cond, off};
        bus.bus_in = operand;
        bus.pc_in  = pc;
        bus.start  = 1'b1;
    endtask

    // Full operation from the start edge to one cycle after done; operands
    // are scrambled right after the start edge.
    task automatic branch_op(input string tag, input logic [1:0] cond,
                             input logic [31:0] operand, input logic [31:0] pc,
                             input logic [18:0] off, input logic exp_con,
                             input logic [31:0] exp_pc);
        drive_op(cond, operand, pc, off);
        next_cycle();
        bus.start  = 1'b0;
        bus.ir     = ~bus.ir;
        bus.bus_in = ~operand;
        bus.pc_in  = pc ^ 32'h0000_FFFF;
        check({tag, "_busy"}, bus.busy, 1);
        next_cycle();
        check({tag, "_con_q"}, bus.con_q, exp_con);
        next_cycle();
        check({tag, "_pc_out"}, bus.pc_out, exp_pc);
        check({tag, "_done_early"}, bus.done, 0);
        next_cycle();
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_pc_load"}, bus.pc_load, exp_con);
        check({tag, "_idle"}, bus.busy, 0);
        next_cycle();
        check({tag, "_done_end"}, bus.done, 0);
        check({tag, "_pc_load_end"}, bus.pc_load, 0);
    endtask

    initial begin
        applied     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        bus.start   = 1'b0;
        bus.flush   = 1'b0;
        bus.ir      = '0;
        bus.bus_in  = '0;
        bus.pc_in   = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_con_q", bus.con_q, 0);
        check("rst_pc_out", bus.pc_out, 0);
        check("rst_pc_load", bus.pc_load, 0);
        check("rst_done", bus.done, 0);
        check("rst_branch_count", bus.branch_count, 0);
        check("rst_taken_count", bus.taken_count, 0);
        reset_n = 1'b1;
        next_cycle();

        // Equal-zero, positive displacement
        branch_op("eqz", 2'b00, 32'h0, 32'h100, 19'h10, 1'b1, 32'h110);
        // Less-than-zero, negative displacement (-4)
        branch_op("ltz", 2'b11, 32'hFFFF_FFFF, 32'h8, 19'h7FFFC, 1'b1, 32'h4);
        // Greater-than-zero with most negative operand: not taken
        branch_op("gtz_neg", 2'b10, 32'h8000_0000, 32'h200, 19'h4, 1'b0, 32'h204);
        check("stats3_branch", bus.branch_count, BR3);
        check("stats3_taken", bus.taken_count, TK3);

        // Wrap-around of the target
        branch_op("wrap", 2'b01, 32'h5, 32'hFFFF_FFF0, 19'h20, 1'b1, 32'h10);
        // Greater-than-zero taken, displacement -1
        branch_op("gtz_pos", 2'b10, 32'h5, 32'h300, 19'h7FFFF, 1'b1, 32'h2FF);
        // Not-equal-zero with zero operand: not taken
        branch_op("nez_zero", 2'b01, 32'h0, 32'h0, 19'h0, 1'b0, 32'h0);

        // Start while busy is ignored and not queued
        drive_op(2'b01, 32'h7, 32'h40, 19'h4);
        next_cycle();
        drive_op(2'b00, 32'h5, 32'h900, 19'h100);
        next_cycle();
        bus.start = 1'b0;
        check("busy_start_con_q", bus.con_q, 1);
        next_cycle();
        check("busy_start_pc_out", bus.pc_out, 32'h44);
        next_cycle();
        check("busy_start_done", bus.done, 1);
        check("busy_start_pc_load", bus.pc_load, 1);
        next_cycle();
        check("busy_start_noqueue", bus.busy, 0);
        next_cycle();
        check("busy_start_noqueue2", bus.busy, 0);
        check("busy_start_nodone", bus.done, 0);

        // Flush in CALC: no done, values retained, not counted
        drive_op(2'b00, 32'h0, 32'h1000, 19'h8);
        next_cycle();
        bus.start = 1'b0;
        check("flush_busy_eval", bus.busy, 1);
        next_cycle();
        check("flush_con_q", bus.con_q, 1);
        bus.flush = 1'b1;
        next_cycle();
        bus.flush = 1'b0;
        check("flush_idle", bus.busy, 0);
        check("flush_done", bus.done, 0);
        check("flush_pc_out_kept", bus.pc_out, 32'h44);
        check("flush_con_q_kept", bus.con_q, 1);
        next_cycle();
        check("flush_done2", bus.done, 0);
        check("flush_pc_load2", bus.pc_load, 0);
        check("stats7_branch", bus.branch_count, BR7);
        check("stats7_taken", bus.taken_count, TK7);

        // Flush and start together in IDLE
        drive_op(2'b00, 32'h0, 32'h10, 19'h1);
        bus.flush = 1'b1;
        next_cycle();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start_idle", bus.busy, 0);
        next_cycle();
        check("flush_start_idle2", bus.busy, 0);
        check("flush_start_nodone", bus.done, 0);

        // Asynchronous reset in EVAL
        drive_op(2'b00, 32'h0, 32'h2000, 19'h4);
        next_cycle();
        bus.start = 1'b0;
        check("areset_in_eval", bus.busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_busy", bus.busy, 0);
        check("areset_con_q", bus.con_q, 0);
        check("areset_pc_out", bus.pc_out, 0);
        check("areset_pc_load", bus.pc_load, 0);
        check("areset_done", bus.done, 0);
        check("areset_branch_count", bus.branch_count, 0);
        check("areset_taken_count", bus.taken_count, 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            check("areset_no_complete", {bus.busy, bus.done, bus.pc_load}, 0);
        end

        // Recovery after reset
        branch_op("recover", 2'b00, 32'h0, 32'h100, 19'h10, 1'b1, 32'h110);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
